lcd_bus_arbiter: RTL and testbench
==================================

// Module: lcd_bus_arbiter
// PURPOSE
//  Round-robin arbiter that shares one character-LCD controller among NREQ requesters.
//  Each requester posts a 10-bit command/data word {rs, rw, data[7:0]}.
//  The arbiter runs the lcd_enable/busy handshake and returns a one-cycle ack per word.
//  A watchdog aborts any transfer whose handshake stalls.
//  Sits between application logic (menu/status writers) and the LCD controller.
// PARAMETERS
//  NREQ     2     number of requesters, 2..4
//  TIMEOUT  4095  max cycles in ISSUE+WAIT_DONE before abort, 1..65535
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  rst        in   1          asynchronous, active-high reset
//  req        in   NREQ       req[i]=1: requester i has a word pending
//  req_word   in   10*NREQ    word i = req_word[10*i+9 : 10*i] = {rs, rw, data[7:0]}
//  ack        out  NREQ       one-cycle pulse to the owner when its transfer completes or aborts
//  lcd_enable out  1          request strobe to the LCD controller
//  lcd_bus    out  10         word driven to the LCD controller
//  lcd_busy   in   1          controller busy (high during power-up/init and during each transfer)
//  err        out  1          sticky: a transfer was aborted by the watchdog
//  owner      out  2          index of the current/last granted requester
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, ptr=0, owner=0, ack=0, lcd_enable=0, lcd_bus=0, err=0, wdog=0.
//    All outputs are registered.
//  - FSM states: IDLE, ISSUE, WAIT_DONE, ACK.
//  - IDLE, with any req high and lcd_busy=0:
//    - Grant the first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
//    - Latch req_word[i] into lcd_bus; set owner=i; go to ISSUE.
//    - A grant is never made while lcd_busy=1, so the controller's init phase is honoured.
//  - ISSUE:
//    - lcd_enable=1, lcd_bus held.
//    - When lcd_busy is sampled 1: lcd_enable=0 next cycle, go to WAIT_DONE.
//  - WAIT_DONE:
//    - lcd_enable=0.
//    - When lcd_busy is sampled 0: go to ACK.
//  - ACK:
//    - ack[owner]=1 for exactly one cycle.
//    - ptr=(owner+1) mod NREQ; lcd_bus keeps the last word.
//    - Go to IDLE. A re-arbitration can grant at the earliest one cycle after the ack pulse.
//  - Latency: req rising edge with bus idle -> lcd_enable high 1 cycle later.
//  - Watchdog:
//    - wdog is a 16-bit counter, cleared on entry to ISSUE, incremented each cycle in ISSUE/WAIT_DONE.
//    - At wdog==TIMEOUT: err=1 (sticky until rst), lcd_enable=0, go to ACK (ack still pulses).
//    - A handshake completion in the same cycle as the timeout counts as completion; err is not set.
//  - Requesters hold req until ack. Deasserting req after grant does not cancel the transfer.
//    req_word changes after grant are ignored; the word is latched at grant.
//  - Simultaneous requests: the strict round-robin pointer guarantees no requester waits more than NREQ-1 transfers.
//  - Requests whose owner is not in ACK never see ack. At most one ack bit is high per cycle.
//  - rst mid-transfer: immediate return to reset values. The LCD controller may still finish its cycle.
//    The next grant waits for lcd_busy=0.
// TESTING
//  1. Reset: rst=1 mid-ISSUE -> all outputs 0 within the same cycle; IDLE after release.
//  2. Init gating: lcd_busy=1 for 100 cycles, req=2'b01 -> no lcd_enable until busy falls;
//     then lcd_bus=word0 and ack[0] after the handshake.
//  3. Round robin: NREQ=2, req=2'b11 held -> grant order 0,1,0,1.
//     Each ack is one cycle; owner toggles; lcd_bus alternates word0/word1.
//  4. Handshake: model busy high 3 cycles after enable, for 2250 cycles ->
//     lcd_enable drops the cycle after busy=1; ack 1 cycle after busy falls.
//  5. Watchdog: TIMEOUT=20, lcd_busy stuck 0 after grant -> err=1 and ack[owner] at cycle 20;
//     err stays 1 through later good transfers.
//  6. Word latch: change req_word[0] to 10'h3FF after grant -> lcd_bus keeps the originally latched value.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin sharing of one character-LCD controller with a stall watchdog
module lcd_bus_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [10*NREQ-1:0]   req_word,
  output logic [NREQ-1:0]      ack,
  output logic                 lcd_enable,
  output logic [9:0]           lcd_bus,
  input  logic                 lcd_busy,
  output logic                 err,
  output logic [1:0]           owner
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_DONE = 2'd2, ACK = 2'd3;
  logic [1:0]  state, ptr, gnt, j;
  logic        any, tmo;
  logic [15:0] wdog;
  logic [3:0]  req4;
  logic [39:0] word4;
  logic [9:0]  words [4];
  assign req4  = 4'(req);
  assign word4 = 40'(req_word);
  // the watchdog fires on the cycle its count would reach TIMEOUT
  assign tmo = (wdog + 16'd1) == 16'(TIMEOUT);
  // pick the first pending requester at or after the round-robin pointer
  always_comb begin
    gnt = ptr;
    any = 1'b0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = 2'((32'(ptr) + k) % NREQ);
      if (req4[j]) begin
        gnt = j;
        any = 1'b1;
      end
    end
  end
  // unpack the request words so they can be selected by grant index
  always_comb begin
    for (int i = 0; i < 4; i++) words[i] = word4[10*i +: 10];
  end
  // handshake FSM; completion in WAIT_DONE wins over a simultaneous timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      ack        <= '0;
      lcd_enable <= 1'b0;
      lcd_bus    <= '0;
      err        <= 1'b0;
      wdog       <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (any && !lcd_busy) begin
          lcd_bus    <= words[gnt];
          owner      <= gnt;
          lcd_enable <= 1'b1;
          wdog       <= '0;
          state      <= ISSUE;
        end
        ISSUE: begin
          wdog <= wdog + 16'd1;
          if (tmo) begin
            err        <= 1'b1;
            lcd_enable <= 1'b0;
            ack        <= NREQ'(4'b1 << owner);
            state      <= ACK;
          end else if (lcd_busy) begin
            lcd_enable <= 1'b0;
            state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          wdog <= wdog + 16'd1;
          if (!lcd_busy || tmo) begin
            err   <= err | lcd_busy;
            ack   <= NREQ'(4'b1 << owner);
            state <= ACK;
          end
        end
        default: begin
          ptr   <= 2'((32'(owner) + 1) % NREQ);
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: table-driven and sequence checks for lcd_bus_arbiter
module tb_lcd_bus_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [19:0] req_word;
  logic [1:0] ack;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       lcd_busy;
  logic       err;
  logic [1:0] owner;
  logic       busy_man = 1'b0;
  logic       busy_auto = 1'b0;
  bit         auto_busy = 1'b0;
  int         bcnt = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic [1:0] req;
    logic [9:0] w0;
    logic       busy;
    logic       en;
    logic [9:0] bus;
    logic [1:0] ack;
    logic [1:0] own;
  } vec_t;

  always #5 clk = ~clk;
  assign lcd_busy = auto_busy ? busy_auto : busy_man;

  lcd_bus_arbiter #(.NREQ(2), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req(req), .req_word(req_word), .ack(ack),
    .lcd_enable(lcd_enable), .lcd_bus(lcd_bus), .lcd_busy(lcd_busy),
    .err(err), .owner(owner)
  );

  // controller model: busy rises when enable is seen and stays high 3 cycles
  initial forever begin
    @(negedge clk);
    if (!auto_busy) begin
      bcnt = 0;
      busy_auto = 1'b0;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) busy_auto = 1'b0;
    end else if (lcd_enable && !busy_auto) begin
      busy_auto = 1'b1;
      bcnt = 3;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    busy_man = 1'b0;
    auto_busy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vec_t tv[16];
    int   t, en_cnt, nacks;
    logic [1:0] exp_own;
    logic prev1, prev2, fell;
    logic [9:0] w [2];
    tv[0]  = '{2'b01, 10'h141, 1'b1, 1'b0, 10'h000, 2'b00, 2'd0};
    tv[1]  = '{2'b01, 10'h141, 1'b0, 1'b1, 10'h141, 2'b00, 2'd0};
    tv[2]  = '{2'b01, 10'h141, 1'b0, 1'b1, 10'h141, 2'b00, 2'd0};
    tv[3]  = '{2'b01, 10'h141, 1'b1, 1'b0, 10'h141, 2'b00, 2'd0};
    tv[4]  = '{2'b01, 10'h141, 1'b1, 1'b0, 10'h141, 2'b00, 2'd0};
    tv[5]  = '{2'b01, 10'h141, 1'b0, 1'b0, 10'h141, 2'b01, 2'd0};
    tv[6]  = '{2'b00, 10'h141, 1'b0, 1'b0, 10'h141, 2'b00, 2'd0};
    tv[7]  = '{2'b11, 10'h141, 1'b0, 1'b1, 10'h2A5, 2'b00, 2'd1};
    tv[8]  = '{2'b11, 10'h141, 1'b1, 1'b0, 10'h2A5, 2'b00, 2'd1};
    tv[9]  = '{2'b11, 10'h141, 1'b0, 1'b0, 10'h2A5, 2'b10, 2'd1};
    tv[10] = '{2'b11, 10'h141, 1'b0, 1'b0, 10'h2A5, 2'b00, 2'd1};
    tv[11] = '{2'b11, 10'h141, 1'b0, 1'b1, 10'h141, 2'b00, 2'd0};
    tv[12] = '{2'b11, 10'h3FF, 1'b1, 1'b0, 10'h141, 2'b00, 2'd0};
    tv[13] = '{2'b10, 10'h3FF, 1'b0, 1'b0, 10'h141, 2'b01, 2'd0};
    tv[14] = '{2'b10, 10'h3FF, 1'b0, 1'b0, 10'h141, 2'b00, 2'd0};
    tv[15] = '{2'b10, 10'h3FF, 1'b0, 1'b1, 10'h2A5, 2'b00, 2'd1};
    req_word = '0;
    do_reset();
    chk("rst_enable", lcd_enable, 0);
    chk("rst_bus", lcd_bus, 0);
    chk("rst_ack", ack, 0);
    chk("rst_owner", owner, 0);
    chk("rst_err", err, 0);

    for (int i = 0; i < 16; i++) begin
      req = tv[i].req;
      req_word = {10'h2A5, tv[i].w0};
      busy_man = tv[i].busy;
      tick();
      chk($sformatf("tv%0d_enable", i), lcd_enable, tv[i].en);
      chk($sformatf("tv%0d_bus", i), lcd_bus, tv[i].bus);
      chk($sformatf("tv%0d_ack", i), ack, tv[i].ack);
      chk($sformatf("tv%0d_owner", i), owner, tv[i].own);
      chk($sformatf("tv%0d_err", i), err, 0);
    end

    // asynchronous reset while in ISSUE, away from any clock edge
    #2 rst = 1'b1;
    #1;
    chk("amid_enable", lcd_enable, 0);
    chk("amid_bus", lcd_bus, 0);
    chk("amid_owner", owner, 0);
    chk("amid_ack", ack, 0);
    tick();
    rst = 1'b0;
    req = 2'b11;
    req_word = {10'h2A5, 10'h141};
    busy_man = 1'b0;
    tick();
    chk("post_rst_grant_owner", owner, 0);
    chk("post_rst_grant_enable", lcd_enable, 1);

    // init gating: no grant while the controller is busy
    do_reset();
    req = 2'b01;
    req_word = {10'h2A5, 10'h0C3};
    busy_man = 1'b1;
    en_cnt = 0;
    repeat (100) begin
      tick();
      if (lcd_enable) en_cnt++;
    end
    chk("init_no_enable", en_cnt, 0);
    auto_busy = 1'b1;
    t = 0;
    while (ack == 2'b00 && t < 20) begin
      tick();
      t++;
    end
    chk("init_ack", ack, 2'b01);
    chk("init_bus", lcd_bus, 10'h0C3);

    // round robin with the controller model over a long run
    do_reset();
    w[0] = 10'h141;
    w[1] = 10'h2A5;
    req_word = {w[1], w[0]};
    req = 2'b11;
    auto_busy = 1'b1;
    exp_own = 2'd0;
    nacks = 0;
    prev1 = 1'b0;
    prev2 = 1'b0;
    for (int c = 0; c < 2250; c++) begin
      tick();
      fell = prev2 && !prev1;
      if (prev1) chk("enable_drop", lcd_enable, 0);
      chk("ack_after_busy_fall", ack != 2'b00, fell);
      if (ack != 2'b00) begin
        chk("rr_ack", ack, 2'b01 << exp_own);
        chk("rr_owner", owner, exp_own);
        chk("rr_bus", lcd_bus, w[exp_own[0]]);
        exp_own = exp_own ^ 2'd1;
        nacks++;
      end
      prev2 = prev1;
      prev1 = lcd_busy;
    end
    chk("rr_enough_acks", nacks >= 4, 1);
    chk("rr_err", err, 0);

    // completion on the same cycle the watchdog would fire
    do_reset();
    req = 2'b01;
    req_word = {10'h2A5, 10'h155};
    tick();
    chk("bnd_grant", lcd_enable, 1);
    busy_man = 1'b1;
    repeat (19) tick();
    chk("bnd_no_early_ack", ack, 0);
    busy_man = 1'b0;
    tick();
    chk("bnd_ack", ack, 2'b01);
    chk("bnd_no_err", err, 0);
    req = 2'b00;
    tick();
    tick();

    // watchdog abort with busy stuck low
    req = 2'b01;
    tick();
    chk("wd_grant", lcd_enable, 1);
    repeat (19) tick();
    chk("wd_ack_before", ack, 0);
    chk("wd_err_before", err, 0);
    chk("wd_enable_before", lcd_enable, 1);
    tick();
    chk("wd_err", err, 1);
    chk("wd_ack", ack, 2'b01);
    chk("wd_enable_off", lcd_enable, 0);
    req = 2'b00;
    tick();
    req = 2'b10;
    auto_busy = 1'b1;
    t = 0;
    while (ack == 2'b00 && t < 30) begin
      tick();
      t++;
    end
    chk("wd_good_ack", ack, 2'b10);
    chk("wd_err_sticky", err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
